seq_product_unit: RTL and testbench
===================================

# seq_product_unit

Parametrised sequential product engine for the Lab 4 datapath. It reads COUNT unsigned operands from byte-wide data memory starting at a given address, multiplies them with a shift-add multiplier at one bit per cycle, and writes the truncated RESULT_W-bit product back MSB-first immediately after the operands. It generalises the fixed three-operand, 16-bit "product" program into a hardware block, adding a configurable operand count and result width, an overflow flag and a busy indication.

## Interface
- DATA_W, 8, operand width; also the memory data width
- ADDR_W, 8, memory address width; addresses wrap modulo 2^ADDR_W
- COUNT, 3, number of operands; must be ≥ 1
- RESULT_W, 16, result width; must be a multiple of DATA_W and ≥ DATA_W
- clock  in  1  system clock; all state changes on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  level, sampled in IDLE/DONE; high begins a run
- start_address  in  ADDR_W  base address of operand 0; latched when start is sampled
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_rd
- mem_addr  out  ADDR_W  memory address
- mem_rd  out  1  read strobe
- mem_wr  out  1  write strobe
- mem_wdata  out  DATA_W  write data
- busy  out  1  high in FETCH/LOAD/MUL/WRITE
- done  out  1  high in DONE, held until the next run starts
- overflow  out  1  sticky per run; the true product exceeded RESULT_W bits
- result  out  RESULT_W  accumulated product; valid while done is high

## Operation
- States: IDLE, FETCH, LOAD, MUL, WRITE, DONE.
- IDLE/DONE, start=1: latch base=start_address, acc=1, idx=0, overflow=0, clear done, go to FETCH. start=0: stay. start is ignored in every other state.
- FETCH: mem_addr=base+idx, mem_rd=1, go to LOAD.
- LOAD: mcand=mem_rdata, part=0, shifted=acc (width RESULT_W+DATA_W), bit=0, go to MUL.
- MUL, one cycle per bit, DATA_W cycles:
  - If mcand[0] then part += shifted.
  - mcand>>=1, shifted<<=1, bit++.
  - On the last bit: acc=part[RESULT_W-1:0], overflow |= |part[upper DATA_W bits]; then if idx==COUNT-1 go to WRITE (k=0), else idx++ and go to FETCH.
- WRITE: RESULT_W/DATA_W cycles. mem_wr=1, mem_addr=base+COUNT+k, mem_wdata=acc slice k, MSB slice first. Go to DONE after the last slice.
- DONE: done=1, result=acc.
- Arithmetic: unsigned only; the product is kept modulo 2^RESULT_W; overflow is set if any intermediate product exceeds RESULT_W bits.
- Address arithmetic wraps modulo 2^ADDR_W.

## Timing
- Reset values (async on reset_n low): state=IDLE; all outputs 0 (mem_addr, mem_rd, mem_wr, mem_wdata, busy, done, overflow, result). Reset during any state aborts the run; no further memory writes occur.
- mem_rd/mem_wr/mem_addr/mem_wdata are registered and never high in the same cycle.
- Per operand: 2 + DATA_W cycles.
- done rises 1 + COUNT·(DATA_W+2) + RESULT_W/DATA_W edges after the edge that samples start. Default: 33.
- Partial results written before a reset remain in memory; the block does not roll them back.

## Structure
- Package product_pkg:
  - state_t enum (IDLE, FETCH, LOAD, MUL, WRITE, DONE)
  - default parameter constants
  - a localparam function computing latency, for bench use
- Sub-module shift_add_step: combinational single-bit multiply step, inputs part/shifted/mcand, outputs the next values. The FSM, counters and memory sequencing stay in seq_product_unit.
- Bench: behavioural byte-wide memory model with 1-cycle read latency; clock period 20 ns.

## Test plan
- Defaults; mem[0..2]=53,17,42; start_address=0; start pulse -> mem[3]=147, mem[4]=210, result=37842, overflow=0, done at edge 33.
- mem=255,255,255 -> result=0x02FF, mem[3]=2, mem[4]=255, overflow=1.
- mem=0,200,7 -> mem[3]=0, mem[4]=0, overflow=0; start re-asserted while busy has no effect on timing or result.
- start_address=254, operands at 254, 255, 0 = 3, 5, 7 -> writes 0 at addr 1 and 105 at addr 2 (wrap-around).
- reset_n low mid-MUL of operand 2 -> all outputs 0 immediately; no mem_wr afterwards; a subsequent normal run gives the correct result.
- COUNT=4, RESULT_W=32; mem=2,3,5,7 -> bytes 0,0,0,210 at addr 4..7, done at edge 1+40+4=45.

Source files
------------

// File: rtl/product_pkg.sv
// Shared types and constants for the sequential product engine.
package product_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        MUL   = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam int unsigned DEF_DATA_W   = 8;
    localparam int unsigned DEF_ADDR_W   = 8;
    localparam int unsigned DEF_COUNT    = 3;
    localparam int unsigned DEF_RESULT_W = 16;

    // Edges from the start-sampling edge (counted as edge 1) to done going high.
    function automatic int unsigned latency(input int unsigned count,
                                            input int unsigned data_w,
                                            input int unsigned result_w);
        return 1 + count * (data_w + 2) + result_w / data_w;
    endfunction

endpackage

// File: rtl/shift_add_step.sv
// One bit of a shift-add multiply: conditional accumulate, then shift both operands.
module shift_add_step
    import product_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned PROD_W = DEF_RESULT_W + DEF_DATA_W
) (
    input  logic [PROD_W-1:0] part,
    input  logic [PROD_W-1:0] shifted,
    input  logic [DATA_W-1:0] mcand,
    output logic [PROD_W-1:0] part_next_c,
    output logic [PROD_W-1:0] shifted_next_c,
    output logic [DATA_W-1:0] mcand_next_c
);

    always_comb begin
        part_next_c    = mcand[0] ? part + shifted : part;
        shifted_next_c = shifted << 1;
        mcand_next_c   = mcand >> 1;
    end

endmodule

// File: rtl/seq_product_unit.sv
// Reads COUNT operands from byte memory, multiplies them bit-serially and
// writes the truncated product back MSB slice first after the operands.
module seq_product_unit
    import product_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned COUNT    = DEF_COUNT,
    parameter int unsigned RESULT_W = DEF_RESULT_W
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_address,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [RESULT_W-1:0] result
);

    localparam int unsigned PROD_W = RESULT_W + DATA_W;
    localparam int unsigned NSLICE = RESULT_W / DATA_W;
    localparam int unsigned IDX_W  = $clog2(COUNT + 1);
    localparam int unsigned BIT_W  = $clog2(DATA_W + 1);
    localparam int unsigned K_W    = $clog2(NSLICE + 1);

    state_t              state, state_d;
    logic [ADDR_W-1:0]   base, base_d;
    logic [IDX_W-1:0]    idx, idx_d;
    logic [K_W-1:0]      k, k_d;
    logic [BIT_W-1:0]    bit_cnt, bit_d;
    logic [DATA_W-1:0]   mcand, mcand_d;
    logic [PROD_W-1:0]   part, part_d;
    logic [PROD_W-1:0]   shifted, shifted_d;
    logic [RESULT_W-1:0] acc, acc_d;
    logic                ovf_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic                mem_rd_d, mem_wr_d, busy_d, done_d;
    logic [DATA_W-1:0]   mem_wdata_d;
    logic [RESULT_W-1:0] result_d;

    logic [PROD_W-1:0]   step_part, step_shifted;
    logic [DATA_W-1:0]   step_mcand;

    shift_add_step #(
        .DATA_W (DATA_W),
        .PROD_W (PROD_W)
    ) u_step (
        .part           (part),
        .shifted        (shifted),
        .mcand          (mcand),
        .part_next_c    (step_part),
        .shifted_next_c (step_shifted),
        .mcand_next_c   (step_mcand)
    );

    // State, datapath and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            base      <= '0;
            idx       <= '0;
            k         <= '0;
            bit_cnt   <= '0;
            mcand     <= '0;
            part      <= '0;
            shifted   <= '0;
            acc       <= '0;
            overflow  <= 1'b0;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
        end else begin
            state     <= state_d;
            base      <= base_d;
            idx       <= idx_d;
            k         <= k_d;
            bit_cnt   <= bit_d;
            mcand     <= mcand_d;
            part      <= part_d;
            shifted   <= shifted_d;
            acc       <= acc_d;
            overflow  <= ovf_d;
            mem_addr  <= mem_addr_d;
            mem_rd    <= mem_rd_d;
            mem_wr    <= mem_wr_d;
            mem_wdata <= mem_wdata_d;
            busy      <= busy_d;
            done      <= done_d;
            result    <= result_d;
        end
    end

    // Next state and next register values; outputs are decoded from the
    // next state so each strobe is registered in step with its state.
    always_comb begin
        state_d   = state;
        base_d    = base;
        idx_d     = idx;
        k_d       = k;
        bit_d     = bit_cnt;
        mcand_d   = mcand;
        part_d    = part;
        shifted_d = shifted;
        acc_d     = acc;
        ovf_d     = overflow;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_d = FETCH;
                    base_d  = start_address;
                    acc_d   = RESULT_W'(1);
                    idx_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                mcand_d   = mem_rdata;
                part_d    = '0;
                shifted_d = PROD_W'(acc);
                bit_d     = '0;
                state_d   = MUL;
            end
            MUL: begin
                part_d    = step_part;
                shifted_d = step_shifted;
                mcand_d   = step_mcand;
                bit_d     = bit_cnt + 1'b1;
                if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                    acc_d = step_part[RESULT_W-1:0];
                    ovf_d = overflow | (|step_part[PROD_W-1:RESULT_W]);
                    if (idx == IDX_W'(COUNT - 1)) begin
                        k_d     = '0;
                        state_d = WRITE;
                    end else begin
                        idx_d   = idx + 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            WRITE: begin
                if (k == K_W'(NSLICE - 1)) begin
                    state_d = DONE;
                end else begin
                    k_d = k + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        mem_rd_d    = (state_d == FETCH);
        mem_wr_d    = (state_d == WRITE);
        busy_d      = (state_d == FETCH) || (state_d == LOAD) ||
                      (state_d == MUL)   || (state_d == WRITE);
        done_d      = (state_d == DONE);
        result_d    = (state_d == DONE) ? acc_d : result;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        if (state_d == FETCH) begin
            mem_addr_d = base_d + ADDR_W'(idx_d);
        end else if (state_d == WRITE) begin
            mem_addr_d  = base_d + ADDR_W'(COUNT) + ADDR_W'(k_d);
            mem_wdata_d = DATA_W'(acc_d >> (DATA_W * (NSLICE - 1 - 32'(k_d))));
        end
    end

endmodule

// File: tb/tb_seq_product_unit.sv
// Scoreboard bench for seq_product_unit: randomized runs against an arithmetic reference.
`timescale 1ns/1ps
module tb_seq_product_unit;
    import product_pkg::*;

    localparam int unsigned LAT  = latency(3, 8, 16);
    localparam int unsigned LAT4 = latency(4, 8, 32);

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  start_address = '0;
    logic [7:0]  mem_rdata;
    logic [7:0]  mem_addr;
    logic        mem_rd, mem_wr;
    logic [7:0]  mem_wdata;
    logic        busy, done, overflow;
    logic [15:0] result;

    logic        start4 = 1'b0;
    logic [7:0]  start_address4 = '0;
    logic [7:0]  mem_rdata4;
    logic [7:0]  mem_addr4;
    logic        mem_rd4, mem_wr4;
    logic [7:0]  mem_wdata4;
    logic        busy4, done4, overflow4;
    logic [31:0] result4;

    seq_product_unit u_dut (
        .clock(clock), .reset_n(reset_n), .start(start), .start_address(start_address),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .overflow(overflow), .result(result)
    );

    seq_product_unit #(.DATA_W(8), .ADDR_W(8), .COUNT(4), .RESULT_W(32)) u_dut4 (
        .clock(clock), .reset_n(reset_n), .start(start4), .start_address(start_address4),
        .mem_rdata(mem_rdata4), .mem_addr(mem_addr4), .mem_rd(mem_rd4), .mem_wr(mem_wr4),
        .mem_wdata(mem_wdata4), .busy(busy4), .done(done4), .overflow(overflow4), .result(result4)
    );

    always #10 clock = ~clock;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned cyc = 0;
    int unsigned wr_count = 0;
    int unsigned both_hi = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Byte memories with one-cycle read latency; the bench preloads via ld_*.
    logic [7:0] mem  [256];
    logic [7:0] mem4 [256];
    logic       ld_en = 1'b0, ld_sel = 1'b0;
    logic [7:0] ld_addr = '0, ld_data = '0;

    always @(posedge clock) begin
        if (ld_en && !ld_sel) mem[ld_addr] <= ld_data;
        if (ld_en && ld_sel)  mem4[ld_addr] <= ld_data;
        if (mem_rd) mem_rdata <= mem[mem_addr];
        if (mem_wr) begin
            mem[mem_addr] <= mem_wdata;
            wr_count <= wr_count + 1;
        end
        if (mem_rd4) mem_rdata4 <= mem4[mem_addr4];
        if (mem_wr4) mem4[mem_addr4] <= mem_wdata4;
    end

    typedef struct {
        logic [15:0] result;
        logic        ovf;
        logic [7:0]  base;
        int unsigned done_cyc;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Product of the operands modulo 2^rw, flagging any intermediate that did not fit.
    function automatic void ref_product(input int unsigned ops[4], input int n, input int unsigned rw,
                                        output longint unsigned prod, output bit ovf);
        longint unsigned lim = longint'(1) << rw;
        prod = 1;
        ovf  = 1'b0;
        for (int i = 0; i < n; i++) begin
            prod = prod * longint'(ops[i]);
            if (prod >= lim) ovf = 1'b1;
            prod = prod % lim;
        end
    endfunction

    function automatic logic [63:0] outs_vec();
        return 64'({mem_addr, mem_rd, mem_wr, mem_wdata, busy, done, overflow, result});
    endfunction

    // Monitor: on each rising done, pop the oldest expectation and compare.
    logic done_q = 1'b0;
    exp_t e;
    logic [7:0] a_hi, a_lo;
    always @(negedge clock) begin
        if (mem_rd && mem_wr) both_hi <= both_hi + 1;
        if (done && !done_q) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(done), 64'(0));
            end else begin
                e = sb.pop_front();
                a_hi = e.base + 8'd3;
                a_lo = e.base + 8'd4;
                check("result", 64'(result), 64'(e.result));
                check("overflow", 64'(overflow), 64'(e.ovf));
                check("mem_hi", 64'(mem[a_hi]), 64'(e.result[15:8]));
                check("mem_lo", 64'(mem[a_lo]), 64'(e.result[7:0]));
                check("done_cycle", 64'(cyc), 64'(e.done_cyc));
                check("busy_in_done", 64'(busy), 64'(0));
            end
        end
        done_q <= done;
    end

    task automatic load(input bit sel, input logic [7:0] addr, input logic [7:0] data);
        ld_en = 1'b1; ld_sel = sel; ld_addr = addr; ld_data = data;
        @(negedge clock);
        ld_en = 1'b0;
    endtask

    task automatic run(input logic [7:0] base, input logic [7:0] o0, input logic [7:0] o1,
                       input logic [7:0] o2, input bit poke);
        int unsigned ops[4];
        longint unsigned prod;
        bit ovf;
        exp_t x;
        load(1'b0, base, o0);
        load(1'b0, base + 8'd1, o1);
        load(1'b0, base + 8'd2, o2);
        ops = '{32'(o0), 32'(o1), 32'(o2), 0};
        ref_product(ops, 3, 16, prod, ovf);
        x.result   = 16'(prod);
        x.ovf      = ovf;
        x.base     = base;
        x.done_cyc = cyc + LAT;
        sb.push_back(x);
        start_address = base;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        if (poke) begin
            repeat (5) @(negedge clock);
            start_address = ~base;
            start = 1'b1;
            repeat (3) @(negedge clock);
            start = 1'b0;
        end
        for (int i = 0; i < int'(LAT) + 20 && sb.size() != 0; i++) @(negedge clock);
        if (sb.size() != 0) begin
            check("done_timeout", 64'(sb.size()), 64'(0));
            sb.delete();
        end
        @(negedge clock);
    endtask

    initial begin
        int unsigned wr_snap;
        int unsigned c0;
        int unsigned i;

        #1;
        check("reset_outputs", outs_vec(), 64'(0));
        check("reset_outputs4", 64'({busy4, done4, overflow4, mem_rd4, mem_wr4, result4}), 64'(0));
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        run(8'd0,   8'd53,  8'd17,  8'd42,  1'b0);
        run(8'd0,   8'd255, 8'd255, 8'd255, 1'b0);
        run(8'h20,  8'd0,   8'd200, 8'd7,   1'b1);
        run(8'd254, 8'd3,   8'd5,   8'd7,   1'b0);
        check("wrap_addr1", 64'(mem[1]), 64'(0));
        check("wrap_addr2", 64'(mem[2]), 64'(105));

        for (int r = 0; r < 8; r++) begin
            if (r % 2 == 0)
                run(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
            else
                run(8'($urandom), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                    8'($urandom_range(0, 15)), 1'($urandom));
        end

        // Abort a run during the third operand's multiply.
        load(1'b0, 8'h43, 8'hAA);
        load(1'b0, 8'h44, 8'hBB);
        load(1'b0, 8'h40, 8'd9);
        load(1'b0, 8'h41, 8'd11);
        load(1'b0, 8'h42, 8'd13);
        start_address = 8'h40;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (24) @(negedge clock);
        check("busy_before_abort", 64'(busy), 64'(1));
        #5;
        reset_n = 1'b0;
        #1;
        check("abort_outputs", outs_vec(), 64'(0));
        wr_snap = wr_count;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (15) @(negedge clock);
        check("abort_no_writes", 64'(wr_count), 64'(wr_snap));
        check("abort_mem_hi", 64'(mem[8'h43]), 64'(8'hAA));
        check("abort_mem_lo", 64'(mem[8'h44]), 64'(8'hBB));
        check("abort_idle_done", 64'(done), 64'(0));

        run(8'h80, 8'd53, 8'd17, 8'd42, 1'b0);

        // Four operands into a 32-bit result.
        load(1'b1, 8'd0, 8'd2);
        load(1'b1, 8'd1, 8'd3);
        load(1'b1, 8'd2, 8'd5);
        load(1'b1, 8'd3, 8'd7);
        start_address4 = 8'd0;
        c0 = cyc;
        start4 = 1'b1;
        @(negedge clock);
        start4 = 1'b0;
        i = 0;
        while (!done4 && i < 200) begin
            @(negedge clock);
            i++;
        end
        check("c4_done_cycle", 64'(cyc - c0), 64'(LAT4));
        check("c4_result", 64'(result4), 64'(210));
        check("c4_overflow", 64'(overflow4), 64'(0));
        check("c4_bytes", 64'({mem4[4], mem4[5], mem4[6], mem4[7]}), 64'(32'd210));

        check("rd_wr_overlap", 64'(both_hi), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
